alarm_clock_multi: RTL and testbench

Next-generation alarm-clock core. It replaces the derived 1 Hz clock with a single-clock design driven by a clock-enable tick. It keeps a 24 h BCD time-of-day with seconds and holds NUM_ALARMS independent alarm channels. Each channel has its own ring / snooze / stop state machine, so sound and display logic can run from the same system clock.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_clock_multi_if.sv | 35 +++
 rtl/alarm_channel.sv | 88 ++++++++
 rtl/alarm_clock_multi.sv | 119 +++++++++++
 tb/tb_alarm_clock_multi.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm clock.
// BCD hh:mm layout, channel state encoding and the load range check.
package alarm_pkg;

  typedef struct packed {
    logic [3:0] hd;
    logic [3:0] ho;
    logic [3:0] md;
    logic [3:0] mo;
  } bcd_hhmm_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  localparam logic [3:0] MAX_HOURDEC      = 4'd2;
  localparam logic [3:0] MAX_HOURONE_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MINDEC       = 4'd5;

  function automatic logic bcd_hhmm_valid(input bcd_hhmm_t t);
    return (t.hd <= MAX_HOURDEC) && (t.ho <= 4'd9) &&
           ((t.hd != MAX_HOURDEC) || (t.ho <= MAX_HOURONE_AT_2)) &&
           (t.md <= MAX_MINDEC) && (t.mo <= 4'd9);
  endfunction

endpackage

// File: rtl/alarm_clock_multi_if.sv
// Control/status bundle between the alarm clock core and its host.
// The host side drives loads, writes and stop/snooze; the core reports time and ring state.
interface alarm_clock_multi_if #(
  parameter int NUM_ALARMS = 4,
  parameter int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
  import alarm_pkg::*;

  logic                  time_ld;
  bcd_hhmm_t             time_init;
  logic                  alm_wr;
  logic [SEL_W-1:0]      alm_sel;
  bcd_hhmm_t             alm_time;
  logic                  alm_en;
  logic                  stop;
  logic                  snooze;
  bcd_hhmm_t             time_now;
  logic [7:0]            sec_now;
  logic                  sec_tick_o;
  logic                  load_err;
  logic [NUM_ALARMS-1:0] ring_vec;
  logic [NUM_ALARMS-1:0] snz_vec;
  logic                  ring;

  modport master (
    output time_ld, time_init, alm_wr, alm_sel, alm_time, alm_en, stop, snooze,
    input  time_now, sec_now, sec_tick_o, load_err, ring_vec, snz_vec, ring
  );

  modport slave (
    input  time_ld, time_init, alm_wr, alm_sel, alm_time, alm_en, stop, snooze,
    output time_now, sec_now, sec_tick_o, load_err, ring_vec, snz_vec, ring
  );

endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time/enable plus the ring/snooze/stop FSM.
// A single down-counter serves both the ring window and the snooze delay.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr,
  input  bcd_hhmm_t wr_time,
  input  logic      wr_en,
  input  bcd_hhmm_t time_now,
  input  logic      min_strobe,
  input  logic      sec_tick,
  input  logic      stop,
  input  logic      snooze,
  output logic      ringing,
  output logic      snoozed
);
  localparam int SNZ_SECS = SNOOZE_MIN * 60;
  localparam int CNT_MAX  = (RING_SECS > SNZ_SECS) ? RING_SECS : SNZ_SECS;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RING = RINGING;
  localparam logic [1:0] S_SNZ  = SNOOZED;

  logic [1:0]    st;
  logic [CW-1:0] cnt;
  bcd_hhmm_t     alarm;
  logic          en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= S_IDLE;
      cnt   <= '0;
      alarm <= '0;
      en    <= 1'b0;
    end else begin
      if (wr) begin
        alarm <= wr_time;
        en    <= wr_en;
      end
      // disabling a channel silences it immediately, whatever it was doing
      if (wr && !wr_en) begin
        st <= S_IDLE;
      end else begin
        case (st)
          S_IDLE: begin
            if (en && min_strobe && (time_now == alarm)) begin
              st  <= S_RING;
              cnt <= CW'(RING_SECS);
            end
          end
          S_RING: begin
            if (stop) begin
              st <= S_IDLE;
            end else if (snooze) begin
              st  <= S_SNZ;
              cnt <= CW'(SNZ_SECS);
            end else if (sec_tick) begin
              cnt <= cnt - CW'(1);
              if (cnt == CW'(1)) st <= S_IDLE;
            end
          end
          S_SNZ: begin
            if (stop) begin
              st <= S_IDLE;
            end else if (sec_tick) begin
              cnt <= cnt - CW'(1);
              if (cnt == CW'(1)) begin
                st  <= S_RING;
                cnt <= CW'(RING_SECS);
              end
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign ringing = (st == S_RING);
  assign snoozed = (st == S_SNZ);

endmodule

// File: rtl/alarm_clock_multi.sv
// Single-clock alarm clock: 1 s tick divider, BCD hh:mm:ss counter,
// write decode and NUM_ALARMS independent alarm channels.
module alarm_clock_multi
  import alarm_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input logic               clk,
  input logic               rst,
  alarm_clock_multi_if.slave bus
);
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [TW-1:0] tick_cnt;
  logic          sec_tick;
  logic          ld_ok, wr_ok, min_strobe, load_err;
  bcd_hhmm_t     hm, hm_n;
  logic [3:0]    sd, so, sd_n, so_n;
  logic [NUM_ALARMS-1:0] ring_v, snz_v;

  assign sec_tick = (tick_cnt == TW'(TICK_DIV - 1));
  assign ld_ok    = bus.time_ld && bcd_hhmm_valid(bus.time_init);
  assign wr_ok    = bus.alm_wr && bcd_hhmm_valid(bus.alm_time) &&
                    (32'(bus.alm_sel) < NUM_ALARMS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tick_cnt <= '0;
    else if (ld_ok || sec_tick) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + TW'(1);
  end

  // ripple-carry BCD increment of hh:mm:ss, wrapping 23:59:59 -> 00:00:00
  always_comb begin
    so_n = so + 4'd1;
    sd_n = sd;
    hm_n = hm;
    if (so == 4'd9) begin
      so_n = '0;
      sd_n = sd + 4'd1;
      if (sd == 4'd5) begin
        sd_n    = '0;
        hm_n.mo = hm.mo + 4'd1;
        if (hm.mo == 4'd9) begin
          hm_n.mo = '0;
          hm_n.md = hm.md + 4'd1;
          if (hm.md == 4'd5) begin
            hm_n.md = '0;
            hm_n.ho = hm.ho + 4'd1;
            if (hm.hd == 4'd2 && hm.ho == 4'd3) begin
              hm_n.hd = '0;
              hm_n.ho = '0;
            end else if (hm.ho == 4'd9) begin
              hm_n.ho = '0;
              hm_n.hd = hm.hd + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hm         <= '0;
      sd         <= '0;
      so         <= '0;
      min_strobe <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_err <= (bus.time_ld && !ld_ok) || (bus.alm_wr && !wr_ok);
      if (ld_ok) begin
        hm         <= bus.time_init;
        sd         <= '0;
        so         <= '0;
        min_strobe <= 1'b0;
      end else if (sec_tick) begin
        hm         <= hm_n;
        sd         <= sd_n;
        so         <= so_n;
        min_strobe <= (sd == 4'd5) && (so == 4'd9);
      end else begin
        min_strobe <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_ok && (bus.alm_sel == SEL_W'(i))),
      .wr_time    (bus.alm_time),
      .wr_en      (bus.alm_en),
      .time_now   (hm),
      .min_strobe (min_strobe),
      .sec_tick   (sec_tick),
      .stop       (bus.stop),
      .snooze     (bus.snooze),
      .ringing    (ring_v[i]),
      .snoozed    (snz_v[i])
    );
  end

  assign bus.time_now   = hm;
  assign bus.sec_now    = {sd, so};
  assign bus.sec_tick_o = sec_tick;
  assign bus.load_err   = load_err;
  assign bus.ring_vec   = ring_v;
  assign bus.snz_vec    = snz_v;
  assign bus.ring       = |ring_v;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi with a 4-cycle second and short ring/snooze.
module tb_alarm_clock_multi;
  import alarm_pkg::*;

  localparam int TICK_DIV   = 4;
  localparam int NUM_ALARMS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alarm_clock_multi_if #(.NUM_ALARMS(NUM_ALARMS)) bus ();

  alarm_clock_multi #(
    .TICK_DIV   (TICK_DIV),
    .NUM_ALARMS (NUM_ALARMS),
    .RING_SECS  (5),
    .SNOOZE_MIN (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // park in the next cycle where sec_tick_o is high
  task automatic to_tick();
    for (int i = 0; i < 2 * TICK_DIV + 2; i++) begin
      if (bus.sec_tick_o) return;
      cyc();
    end
    n_chk++;
    n_err++;
    $display("FAIL tick_wait: no sec_tick_o within %0d cycles", 2 * TICK_DIV + 2);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      to_tick();
      cyc();
    end
  endtask

  task automatic load_time(input logic [15:0] t);
    bus.time_ld   = 1'b1;
    bus.time_init = t;
    cyc();
    bus.time_ld   = 1'b0;
  endtask

  task automatic wr_alarm(input int sel, input logic [15:0] t, input logic en);
    bus.alm_wr   = 1'b1;
    bus.alm_sel  = 2'(sel);
    bus.alm_time = t;
    bus.alm_en   = en;
    cyc();
    bus.alm_wr   = 1'b0;
  endtask

  // load hh:mm just before the target minute and advance to the ring cycle (tick + 2)
  task automatic ring_at(input logic [15:0] t);
    load_time(t);
    run_ticks(59);
    to_tick();
    cyc();
    cyc();
  endtask

  initial begin
    bus.time_ld = 1'b0; bus.time_init = '0; bus.alm_wr = 1'b0; bus.alm_sel = '0;
    bus.alm_time = '0;  bus.alm_en = 1'b0;  bus.stop = 1'b0;   bus.snooze = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", bus.time_now, 16'h0000);
    chk("rst_sec", bus.sec_now, 8'h00);
    chk("rst_ring", {bus.ring, bus.ring_vec, bus.snz_vec}, '0);
    chk("rst_err", bus.load_err, 1'b0);
    chk("rst_tick", bus.sec_tick_o, 1'b0);
    rst = 1'b0;

    // tick every 4th cycle, seconds count 01, 02
    cyc(); cyc();
    chk("tick_lo", bus.sec_tick_o, 1'b0);
    cyc();
    chk("tick_hi1", bus.sec_tick_o, 1'b1);
    cyc();
    chk("sec_01", bus.sec_now, 8'h01);
    chk("tick_lo2", bus.sec_tick_o, 1'b0);
    cyc(); cyc(); cyc();
    chk("tick_hi2", bus.sec_tick_o, 1'b1);
    cyc();
    chk("sec_02", bus.sec_now, 8'h02);

    // midnight wrap and rejected loads
    load_time(16'h2359);
    chk("ld_time", bus.time_now, 16'h2359);
    chk("ld_sec", bus.sec_now, 8'h00);
    run_ticks(60);
    chk("wrap_time", bus.time_now, 16'h0000);
    chk("wrap_sec", bus.sec_now, 8'h00);
    load_time(16'h2400);
    chk("bad_ld_err", bus.load_err, 1'b1);
    chk("bad_ld_time", bus.time_now, 16'h0000);
    cyc();
    chk("err_pulse", bus.load_err, 1'b0);
    wr_alarm(1, 16'h0760, 1'b1);
    chk("bad_wr_err", bus.load_err, 1'b1);

    // ch2 rings 2 cycles after the tick reaching 07:01:00, stops after 5 ticks
    wr_alarm(2, 16'h0701, 1'b1);
    load_time(16'h0700);
    run_ticks(59);
    to_tick();
    chk("ring_t0", bus.ring_vec, 4'b0000);
    cyc();
    chk("ring_t1", bus.ring_vec, 4'b0000);
    cyc();
    chk("ring_t2", bus.ring_vec, 4'b0100);
    chk("ring_or", bus.ring, 1'b1);
    run_ticks(4);
    chk("ring_4t", bus.ring_vec, 4'b0100);
    run_ticks(1);
    chk("ring_auto", bus.ring_vec, 4'b0000);

    // snooze for one minute, then ring again; disabling silences it
    ring_at(16'h0700);
    chk("ring_again", bus.ring_vec, 4'b0100);
    bus.snooze = 1'b1;
    cyc();
    bus.snooze = 1'b0;
    chk("snz_vec", bus.snz_vec, 4'b0100);
    chk("snz_ring", bus.ring, 1'b0);
    run_ticks(59);
    chk("snz_59", {bus.ring_vec, bus.snz_vec}, 8'h04);
    run_ticks(1);
    chk("snz_done", {bus.ring_vec, bus.snz_vec}, 8'h40);
    wr_alarm(2, 16'h0701, 1'b0);
    chk("dis_idle", bus.ring_vec, 4'b0000);

    // two channels on the same minute; stop beats snooze
    wr_alarm(0, 16'h0800, 1'b1);
    wr_alarm(3, 16'h0800, 1'b1);
    ring_at(16'h0759);
    chk("dual_ring", bus.ring_vec, 4'b1001);
    bus.stop = 1'b1; bus.snooze = 1'b1;
    cyc();
    bus.stop = 1'b0; bus.snooze = 1'b0;
    chk("stop_snz", {bus.ring, bus.ring_vec, bus.snz_vec}, '0);
    ring_at(16'h0759);
    bus.snooze = 1'b1;
    cyc();
    bus.snooze = 1'b0;
    chk("dual_snz", bus.snz_vec, 4'b1001);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    chk("stop_from_snz", bus.snz_vec, 4'b0000);

    // asynchronous reset mid-ring
    ring_at(16'h0759);
    chk("pre_rst_ring", bus.ring_vec, 4'b1001);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ring", bus.ring, 1'b0);
    chk("async_time", bus.time_now, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ring_at(16'h0759);
    chk("post_rst_0800", bus.ring_vec, 4'b0000);
    ring_at(16'h2359);
    chk("post_rst_time", bus.time_now, 16'h0000);
    chk("post_rst_0000", bus.ring, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
